// File: rtl/vram_cmd_pkg.sv
// Shared definitions for the VRAM bringup command engine: opcodes, FSM
// state encodings, level-shifter direction constants and a lane helper.
package vram_cmd_pkg;

    localparam logic [7:0] OP_NOOP           = 8'h00;
    localparam logic [7:0] OP_ECHO           = 8'h01;
    localparam logic [7:0] OP_ECHO2          = 8'h02;
    localparam logic [7:0] OP_SOFT_RESET     = 8'h10;
    localparam logic [7:0] OP_SET_ADDR_LO    = 8'h20;
    localparam logic [7:0] OP_SET_ADDR_HI    = 8'h21;
    localparam logic [7:0] OP_SET_DATA_BASE  = 8'h40;
    localparam logic [7:0] OP_WRITE_DURATION = 8'h50;
    localparam logic [7:0] OP_READ_DELAY     = 8'h51;
    localparam logic [7:0] OP_SET_FLAGS      = 8'h60;
    localparam logic [7:0] OP_WRITE          = 8'h80;
    localparam logic [7:0] OP_READ           = 8'h90;

    // Level-shifter direction: the board drives lvl_vd_dir and the
    // pin_bidir_8 dir input straight from vd_oe_o.
    localparam logic LVL_DIR_INPUT  = 1'b0;
    localparam logic LVL_DIR_OUTPUT = 1'b1;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b0000001,
        S_ARG   = 7'b0000010,
        S_EXEC  = 7'b0000100,
        S_WRITE = 7'b0001000,
        S_WHOLD = 7'b0010000,
        S_READ  = 7'b0100000,
        S_DRAIN = 7'b1000000
    } state_t;

    // Index of the lowest set bit of a lane mask (3 when the mask is empty).
    function automatic logic [1:0] first_lane(input logic [3:0] mask);
        logic [1:0] lane;
        if (mask[0]) begin
            lane = 2'd0;
        end else if (mask[1]) begin
            lane = 2'd1;
        end else if (mask[2]) begin
            lane = 2'd2;
        end else begin
            lane = 2'd3;
        end
        return lane;
    endfunction

endpackage

// File: rtl/vram_cmd_engine_if.sv
// UART byte stream, response stream and VRAM pin bundle of the command engine.
interface vram_cmd_engine_if #(
    parameter int ADDR_W = 14,
    parameter int LANES  = 2
);
    logic [7:0]         rx_data_i;
    logic               rx_valid_i;
    logic [7:0]         tx_data_o;
    logic               tx_valid_o;
    logic               tx_ready_i;
    logic [ADDR_W-1:0]  va_o;
    logic [8*LANES-1:0] vd_o;
    logic [8*LANES-1:0] vd_i;
    logic               vd_oe_o;
    logic               vrd_n_o;
    logic [LANES-1:0]   vwr_n_o;
    logic               busy_o;
    logic               err_opcode_o;
    logic               err_overrun_o;

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i, vd_i,
        input  tx_data_o, tx_valid_o, va_o, vd_o, vd_oe_o, vrd_n_o, vwr_n_o,
               busy_o, err_opcode_o, err_overrun_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i, vd_i,
        output tx_data_o, tx_valid_o, va_o, vd_o, vd_oe_o, vrd_n_o, vwr_n_o,
               busy_o, err_opcode_o, err_overrun_o
    );
endinterface

// File: rtl/vram_cmd_engine_byte_fifo.sv
// Small synchronous byte FIFO with a first-word-fall-through head.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data_in,
    input  logic       pop,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign data_out  = mem_r[rd_ptr_r];

    // Storage write; contents need no reset because count_r gates visibility.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/vram_cmd_engine.sv
// UART-driven VRAM bringup engine: two-byte commands set registers and run
// timed write/read cycles; responses leave through a small byte FIFO.
module vram_cmd_engine
    import vram_cmd_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int LANES     = 2,
    parameter int TIMER_W   = 6,
    parameter int OUT_DEPTH = 4
) (
    input logic              clock,
    input logic              reset,
    vram_cmd_engine_if.slave bus
);
    state_t             state_r;
    logic [7:0]         opcode_r;
    logic [7:0]         arg_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [8*LANES-1:0] data_r;
    logic [8*LANES-1:0] rd_data_r;
    logic [TIMER_W-1:0] wdur_r;
    logic [TIMER_W-1:0] rdel_r;
    logic [TIMER_W-1:0] cnt_r;
    logic               autoinc_r;
    logic               vd_oe_r;
    logic               vrd_n_r;
    logic [LANES-1:0]   vwr_n_r;
    logic [LANES-1:0]   pending_r;
    logic               err_opcode_r;
    logic               err_overrun_r;

    logic [LANES-1:0]   mask_s;
    logic [7:0]         inv_arg_s;
    logic [1:0]         lane_s;
    logic [3:0]         lane_bit_s;
    logic               push_s;
    logic [7:0]         push_data_s;
    logic               pop_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [7:0]         fifo_head_s;

    assign mask_s     = arg_r[LANES-1:0];
    assign inv_arg_s  = ~arg_r;
    assign lane_s     = first_lane(4'(pending_r));
    assign lane_bit_s = 4'b0001 << lane_s;
    assign pop_s      = ~fifo_empty_s & bus.tx_ready_i;

    assign bus.tx_data_o     = fifo_head_s;
    assign bus.tx_valid_o    = ~fifo_empty_s;
    assign bus.va_o          = addr_r;
    assign bus.vd_o          = data_r;
    assign bus.vd_oe_o       = vd_oe_r;
    assign bus.vrd_n_o       = vrd_n_r;
    assign bus.vwr_n_o       = vwr_n_r;
    assign bus.busy_o        = (state_r != S_IDLE);
    assign bus.err_opcode_o  = err_opcode_r;
    assign bus.err_overrun_o = err_overrun_r;

    // Response byte source: echo argument at EXEC, queued lane bytes in DRAIN.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = 8'h00;
        if (state_r == S_EXEC && (opcode_r == OP_ECHO || opcode_r == OP_ECHO2)) begin
            push_s      = 1'b1;
            push_data_s = arg_r;
        end else if (state_r == S_DRAIN && pending_r != '0 && !fifo_full_s) begin
            push_s      = 1'b1;
            push_data_s = rd_data_r[8*lane_s +: 8];
        end else begin
            push_s      = 1'b0;
            push_data_s = 8'h00;
        end
    end

    byte_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_s),
        .data_in  (push_data_s),
        .pop      (pop_s),
        .data_out (fifo_head_s),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s)
    );

    // Command FSM with all register-file and strobe updates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            opcode_r      <= 8'h00;
            arg_r         <= 8'h00;
            addr_r        <= '0;
            data_r        <= '0;
            rd_data_r     <= '0;
            wdur_r        <= '1;
            rdel_r        <= '1;
            cnt_r         <= '0;
            autoinc_r     <= 1'b0;
            vd_oe_r       <= 1'b0;
            vrd_n_r       <= 1'b1;
            vwr_n_r       <= '1;
            pending_r     <= '0;
            err_opcode_r  <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.rx_valid_i) begin
                        opcode_r <= bus.rx_data_i;
                        state_r  <= S_ARG;
                    end
                end
                S_ARG: begin
                    if (bus.rx_valid_i) begin
                        arg_r   <= bus.rx_data_i;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_r <= S_IDLE;
                    case (opcode_r)
                        OP_NOOP: begin
                            state_r <= S_IDLE;
                        end
                        OP_ECHO: begin
                            state_r <= S_DRAIN;
                        end
                        OP_ECHO2: begin
                            rd_data_r <= (8*LANES)'(inv_arg_s);
                            pending_r <= LANES'(1'b1);
                            state_r   <= S_DRAIN;
                        end
                        OP_SOFT_RESET: begin
                            addr_r        <= '0;
                            data_r        <= '0;
                            wdur_r        <= '1;
                            rdel_r        <= '1;
                            autoinc_r     <= 1'b0;
                            vd_oe_r       <= 1'b0;
                            vrd_n_r       <= 1'b1;
                            vwr_n_r       <= '1;
                            err_opcode_r  <= 1'b0;
                            err_overrun_r <= 1'b0;
                        end
                        OP_SET_ADDR_LO:    addr_r[7:0]        <= arg_r;
                        OP_SET_ADDR_HI:    addr_r[ADDR_W-1:8] <= arg_r[ADDR_W-9:0];
                        OP_WRITE_DURATION: wdur_r             <= TIMER_W'(arg_r);
                        OP_READ_DELAY:     rdel_r             <= TIMER_W'(arg_r);
                        OP_SET_FLAGS:      autoinc_r          <= arg_r[0];
                        OP_WRITE: begin
                            if (mask_s != '0) begin
                                vd_oe_r <= 1'b1;
                                vwr_n_r <= ~mask_s;
                                cnt_r   <= wdur_r;
                                state_r <= S_WRITE;
                            end
                        end
                        OP_READ: begin
                            if (mask_s != '0) begin
                                vrd_n_r <= 1'b0;
                                cnt_r   <= rdel_r;
                                state_r <= S_READ;
                            end
                        end
                        default: begin
                            // The 4x row is SET_DATA; low nibble selects the lane.
                            if (opcode_r[7:4] == OP_SET_DATA_BASE[7:4] && opcode_r[3:0] < 4'(LANES)) begin
                                data_r[8*opcode_r[3:0] +: 8] <= arg_r;
                            end else begin
                                err_opcode_r <= 1'b1;
                            end
                        end
                    endcase
                end
                S_WRITE: begin
                    if (cnt_r == '0) begin
                        vwr_n_r <= '1;
                        state_r <= S_WHOLD;
                    end else begin
                        cnt_r <= cnt_r - TIMER_W'(1);
                    end
                end
                S_WHOLD: begin
                    vd_oe_r <= 1'b0;
                    if (autoinc_r) begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                    state_r <= S_IDLE;
                end
                S_READ: begin
                    if (cnt_r == '0) begin
                        vrd_n_r   <= 1'b1;
                        rd_data_r <= bus.vd_i;
                        pending_r <= mask_s;
                        if (autoinc_r) begin
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                        state_r <= S_DRAIN;
                    end else begin
                        cnt_r <= cnt_r - TIMER_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (push_s) begin
                        pending_r <= pending_r & ~lane_bit_s[LANES-1:0];
                    end else if (pending_r == '0 && fifo_empty_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
            // Bytes arriving while a command is being executed are dropped.
            if (bus.rx_valid_i && state_r != S_IDLE && state_r != S_ARG) begin
                err_overrun_r <= 1'b1;
            end
        end
    end
endmodule

// File: doc/vram_cmd_engine.md
Name: vram_cmd_engine

Overview:
- UART-byte-driven command processor that runs real read and write cycles on the SNES VRAM bus for bringup.
- Two-byte commands (opcode, arg) arrive from uart_rx. Response bytes go out to uart_tx through a small output FIFO with a valid/ready handshake.
- Generalises the earlier register-only VRAM controller: parametrised lane count, address width and timer width; timed write/read strobes; address auto-increment; overrun detection.

Parameters:
ADDR_W, 14, VRAM address width; legal range 9..16.
LANES, 2, number of 8-bit data lanes (vda, vdb, ...); legal range 1..4.
TIMER_W, 6, width of the write-duration and read-delay registers.
OUT_DEPTH, 4, output FIFO depth in bytes; must be a power of two and at least LANES.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
rx_data_i  in  8  received byte
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
tx_data_o  out  8  byte to transmit
tx_valid_o  out  1  FIFO non-empty; does not depend on tx_ready_i
tx_ready_i  in  1  transmitter can accept a byte
va_o  out  ADDR_W  VRAM address
vd_o  out  8*LANES  write data; lane n occupies bits [8n+7:8n]
vd_i  in  8*LANES  read data
vd_oe_o  out  1  1 = FPGA drives the data pins
vrd_n_o  out  1  read strobe, active-low
vwr_n_o  out  LANES  per-lane write strobe, active-low
busy_o  out  1  state is not IDLE
err_opcode_o  out  1  sticky: bad opcode or lane index out of range
err_overrun_o  out  1  sticky: byte received while not accepting

Behaviour:
- Reset (reset==0 at a clock edge): on the next cycle all outputs take their idle values.
  - tx_valid_o=0, FIFO emptied, va_o=0, vd_o=0, vd_oe_o=0, vrd_n_o=1, vwr_n_o=all 1s.
  - Errors cleared; write_duration and read_delay = all 1s; autoinc=0.
  - This applies mid-cycle too: any strobe in progress deasserts immediately.
- States: IDLE, ARG, EXEC, WRITE, WHOLD, READ, DRAIN.
  - IDLE: on rx_valid_i, latch opcode -> ARG.
  - ARG: on rx_valid_i, latch arg -> EXEC.
  - EXEC lasts exactly one cycle and dispatches the opcode.
- Opcodes:
  - 00 NOOP.
  - 01 ECHO: push arg.
  - 02 ECHO2: push arg, then ~arg.
  - 10 SOFT_RESET: same register effect as reset, but the FIFO is kept.
  - 20 SET_ADDR_LO: addr[7:0]=arg.
  - 21 SET_ADDR_HI: addr[ADDR_W-1:8]=arg[ADDR_W-9:0]; excess arg bits are ignored.
  - 40+n SET_DATA lane n: n>=LANES sets err_opcode.
  - 50 WRITE_DURATION and 51 READ_DELAY: register = arg[TIMER_W-1:0].
  - 60 SET_FLAGS: autoinc=arg[0].
  - 80 WRITE, arg = lane mask.
  - 90 READ, arg = lane mask.
  - Any other opcode: set err_opcode, return to IDLE.
  - Register-only opcodes return to IDLE. ECHO, ECHO2 and READ go through DRAIN.
- Lane mask: bits at or above LANES are ignored. A mask of 0 is a NOOP.
- WRITE:
  - vd_oe_o=1 from the first WRITE cycle.
  - Masked vwr_n lanes are low for exactly write_duration+1 cycles.
  - Then one WHOLD cycle: strobes high, vd_oe_o still 1.
  - Then vd_oe_o=0 and return to IDLE.
  - If autoinc, addr increments at exit and wraps from 2^ADDR_W-1 to 0.
- READ:
  - vd_oe_o=0 and vrd_n_o=0 for read_delay+1 cycles.
  - vd_i is sampled on the last low cycle.
  - vrd_n_o returns high the next cycle.
  - Masked lane bytes are pushed in ascending lane order, then DRAIN.
  - autoinc applies as for WRITE.
- DRAIN: wait until the FIFO is empty, then IDLE. Each command's output is fully sent before the next opcode is accepted.
- FIFO handshake:
  - A byte is consumed when tx_valid_o && tx_ready_i.
  - tx_data_o shows the head byte whenever tx_valid_o=1.
  - Push and pop may occur in the same cycle.
  - Pushes never exceed capacity, because OUT_DEPTH>=LANES and the FIFO is empty at EXEC.
- Overrun: rx_valid_i in EXEC, WRITE, WHOLD, READ or DRAIN drops the byte and sets err_overrun.
- va_o and vd_o reflect the registers continuously. Register changes take effect the cycle after EXEC.

Decomposition:
- Package vram_cmd_pkg holds:
  - opcode localparams (OP_NOOP..OP_READ, OP_SET_DATA_BASE=8'h40);
  - state encodings, one-hot, 7 bits;
  - LVL_DIR_INPUT/OUTPUT constants, shared with the top level.
- One sub-module, byte_fifo (parameter DEPTH): push/data_in, pop/data_out, empty, full; synchronous, active-low reset.
- Top-level bringup wiring maps vd_oe_o to lvl_vd_dir and the pin_bidir_8 dir input.

Test Plan:
- Echo: send 01 A5, tx_ready held 1 -> one byte A5; busy_o returns 0 once the FIFO is empty. Send 02 3C -> bytes 3C then C3.
- Write timing: 50 03, 20 34, 21 12, 40 AA, 41 55, then 80 03 -> va_o=0x1234, vd_o=0x55AA; both vwr_n low exactly 4 cycles; vd_oe_o high 5 cycles; vrd_n_o stays 1.
- Read with backpressure: 51 02, vd_i=0xBEEF, 90 03 with tx_ready low for 10 cycles -> vrd_n_o low exactly 3 cycles; bytes EF then BE; tx_valid_o held and data stable while ready is low.
- Autoinc wrap: 60 01, addr=0x3FFF, 80 01 -> va_o=0x0000 after the write.
- Errors: opcode 7F -> err_opcode=1. Opcode 42 (LANES=2) -> err_opcode=1. A byte during READ -> err_overrun=1. Opcode 10 clears both errors.
- Reset mid-write: reset low during the vwr_n low phase -> next cycle vwr_n all 1s, vd_oe_o=0, va_o=0, tx_valid_o=0; a following 01 11 still echoes 11.
